// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered (1-cycle) ALU among NumReq requesters.
// Results come back tagged with the requester id through a 2-entry response FIFO.
module alu_arbiter #(
  parameter int Width  = 32,
  parameter int NumReq = 4,
  parameter int IdW    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NumReq-1:0]       req_valid,
  output logic [NumReq-1:0]       req_ready,
  input  logic [NumReq*Width-1:0] req_a,
  input  logic [NumReq*Width-1:0] req_b,
  input  logic [NumReq*2-1:0]     req_op,
  output logic [Width-1:0]        alu_a,
  output logic [Width-1:0]        alu_b,
  output logic [1:0]              alu_op,
  input  logic [Width-1:0]        alu_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IdW-1:0]          rsp_id,
  output logic [Width-1:0]        rsp_result,
  output logic                    rsp_err
);

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic             err;
    logic [Width-1:0] result;
  } rsp_t;

  rsp_t           fifo_q [2];
  logic [1:0]     count_q, count_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic           wr_ptr_q, wr_ptr_d;
  logic [IdW-1:0] rr_q, rr_d;
  logic           inflight_q, inflight_err_q;
  logic [IdW-1:0] inflight_id_q;

  logic           pop, push, can_issue, grant_valid, div0;
  logic [IdW-1:0] grant_id;
  logic [2:0]     occupancy;
  int unsigned    scan_idx;
  rsp_t           push_data;

  assign rsp_valid  = (count_q != 2'd0);
  assign rsp_id     = fifo_q[rd_ptr_q].id;
  assign rsp_err    = fifo_q[rd_ptr_q].err;
  assign rsp_result = fifo_q[rd_ptr_q].result;
  assign pop        = rsp_valid & rsp_ready;
  assign push       = inflight_q;

  // Occupancy counts the inflight op too, so a FIFO slot is always reserved before issue.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign can_issue = !rst && (occupancy < 3'd2);

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    scan_idx    = 0;
    for (int i = 1; i <= NumReq; i++) begin
      scan_idx = (int'(rr_q) + i) % NumReq;
      if (!grant_valid && req_valid[scan_idx]) begin
        grant_valid = 1'b1;
        grant_id    = IdW'(scan_idx);
      end
    end
    if (!can_issue) begin
      grant_valid = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = 2'b00;
    if (grant_valid) begin
      req_ready[grant_id] = 1'b1;
      alu_a  = req_a[grant_id*Width +: Width];
      alu_b  = req_b[grant_id*Width +: Width];
      alu_op = req_op[grant_id*2 +: 2];
    end
  end

  assign div0 = grant_valid && (alu_op == 2'b11) && (alu_a == '0);

  always_comb begin
    push_data.id     = inflight_id_q;
    push_data.err    = inflight_err_q;
    push_data.result = inflight_err_q ? {Width{1'b1}} : alu_result;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    rr_d     = grant_valid ? grant_id : rr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q     <= 1'b0;
      inflight_id_q  <= '0;
      inflight_err_q <= 1'b0;
      count_q        <= 2'd0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rr_q           <= IdW'(NumReq - 1);
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      inflight_q <= grant_valid;
      if (grant_valid) begin
        inflight_id_q  <= grant_id;
        inflight_err_q <= div0;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= push_data;
      end
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rr_q     <= rr_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 1-cycle ALU attached to the alu_* ports.
module tb_alu_arbiter;
  localparam int Width  = 32;
  localparam int NumReq = 4;
  localparam int IdW    = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NumReq-1:0]       req_valid;
  logic [NumReq-1:0]       req_ready;
  logic [NumReq*Width-1:0] req_a, req_b;
  logic [NumReq*2-1:0]     req_op;
  logic [Width-1:0]        alu_a, alu_b, alu_result;
  logic [1:0]              alu_op;
  logic                    rsp_valid, rsp_ready, rsp_err;
  logic [IdW-1:0]          rsp_id;
  logic [Width-1:0]        rsp_result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [IdW+Width:0] exp_q[$];

  alu_arbiter #(.Width(Width), .NumReq(NumReq), .IdW(IdW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // External ALU: registered result one cycle after issue.
  always_ff @(posedge clk) begin
    case (alu_op)
      2'b00:   alu_result <= alu_a + alu_b;
      2'b01:   alu_result <= alu_b - alu_a;
      2'b10:   alu_result <= alu_a * alu_b;
      default: alu_result <= (alu_a == '0) ? '0 : alu_b / alu_a;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [Width-1:0] a, input logic [Width-1:0] b,
                         input logic [1:0] op);
    req_a[i*Width +: Width] = a;
    req_b[i*Width +: Width] = b;
    req_op[i*2 +: 2]        = op;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    req_a = '0; req_b = '0; req_op = '0;
    do_reset();
    #1;
    n_checks++;
    if ({rsp_valid, req_ready, rsp_id, rsp_result, rsp_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b ready=%b id=%0d result=%h err=%0b, expected all zero",
               rsp_valid, req_ready, rsp_id, rsp_result, rsp_err);
    end
    n_checks++;
    if ({alu_a, alu_b, alu_op} !== '0) begin
      n_fail++;
      $display("FAIL idle_alu_drive: a=%h b=%h op=%0d, expected zeros", alu_a, alu_b, alu_op);
    end
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 32'd3, 32'd10, 2'b01);
    req_valid = 4'b0001;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_ready: got %b expected 0001", req_ready);
    end
    n_checks++;
    if ({alu_a, alu_b, alu_op} !== {32'd3, 32'd10, 2'b01}) begin
      n_fail++; $display("FAIL single_alu_drive: a=%0d b=%0d op=%0d expected 3 10 1", alu_a, alu_b, alu_op);
    end
    tick();
    req_valid = '0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_early_rsp: rsp_valid=%0b expected 0", rsp_valid);
    end
    tick();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_result} !== {1'b1, 2'd0, 1'b0, 32'd7}) begin
      n_fail++;
      $display("FAIL single_rsp: valid=%0b id=%0d err=%0b result=%0d expected 1 0 0 7",
               rsp_valid, rsp_id, rsp_err, rsp_result);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_pop: rsp_valid=%0b expected 0", rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [IdW+Width:0] exp_v;
    do_reset();
    exp_q.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < NumReq; i++) set_req(i, 32'(i + 1), 32'd100, 2'b00);
    req_valid = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      #1;
      n_checks++;
      if (req_ready !== 4'(1 << (c % 4))) begin
        n_fail++; $display("FAIL rr_grant c=%0d: got %b expected one-hot %0d", c, req_ready, c % 4);
      end
      exp_q.push_back({IdW'(c % 4), 1'b0, 32'(101 + c % 4)});
      n_checks++;
      if (rsp_valid !== (c >= 2)) begin
        n_fail++; $display("FAIL rr_rsp_rate c=%0d: rsp_valid=%0b expected %0b", c, rsp_valid, c >= 2);
      end
      if (rsp_valid && rsp_ready) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({rsp_id, rsp_err, rsp_result} !== exp_v) begin
          n_fail++; $display("FAIL rr_rsp c=%0d: got %h expected %h", c, {rsp_id, rsp_err, rsp_result}, exp_v);
        end
      end
      tick();
    end
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (rsp_valid && rsp_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rr_drain_extra: unexpected rsp id=%0d", rsp_id);
        end else begin
          exp_v = exp_q.pop_front();
          if ({rsp_id, rsp_err, rsp_result} !== exp_v) begin
            n_fail++; $display("FAIL rr_drain: got %h expected %h", {rsp_id, rsp_err, rsp_result}, exp_v);
          end
        end
      end
      tick();
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rr_drain_missing: %0d responses not seen, expected 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] bp_ready [9] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0100,
                                 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [IdW+Width:0] exp_v;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) set_req(i, 32'(i), 32'd20, 2'b01);
    req_valid = 4'b0111;
    for (int c = 0; c < 9; c++) begin
      rsp_ready = (c >= 4);
      #1;
      n_checks++;
      if (req_ready !== bp_ready[c]) begin
        n_fail++; $display("FAIL bp_ready c=%0d: got %b expected %b", c, req_ready, bp_ready[c]);
      end
      for (int i = 0; i < 3; i++)
        if (bp_ready[c][i]) exp_q.push_back({IdW'(i), 1'b0, 32'(20 - i)});
      if (rsp_valid && rsp_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra c=%0d: unexpected rsp id=%0d", c, rsp_id);
        end else begin
          exp_v = exp_q.pop_front();
          if ({rsp_id, rsp_err, rsp_result} !== exp_v) begin
            n_fail++; $display("FAIL bp_rsp c=%0d: got %h expected %h", c, {rsp_id, rsp_err, rsp_result}, exp_v);
          end
        end
      end
      tick();
      req_valid = req_valid & ~bp_ready[c];
    end
    n_checks++;
    if (exp_q.size() != 0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: %0d left, rsp_valid=%0b expected 0 0", exp_q.size(), rsp_valid);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_div_zero();
    do_reset();
    rsp_ready = 1'b1;
    set_req(2, 32'd0, 32'd5, 2'b11);
    set_req(1, 32'd2, 32'd9, 2'b11);
    req_valid = 4'b0100;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL div0_ready: got %b expected 0100", req_ready);
    end
    tick();
    req_valid = 4'b0010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL div_ready: got %b expected 0010", req_ready);
    end
    tick();
    req_valid = '0;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_result} !== {1'b1, 2'd2, 1'b1, 32'hFFFF_FFFF}) begin
      n_fail++; $display("FAIL div0_rsp: valid=%0b id=%0d err=%0b result=%h expected 1 2 1 ffffffff",
                         rsp_valid, rsp_id, rsp_err, rsp_result);
    end
    tick();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_result} !== {1'b1, 2'd1, 1'b0, 32'd4}) begin
      n_fail++; $display("FAIL div_rsp: valid=%0b id=%0d err=%0b result=%h expected 1 1 0 4",
                         rsp_valid, rsp_id, rsp_err, rsp_result);
    end
    tick();
  endtask

  task automatic test_mul_trunc();
    do_reset();
    rsp_ready = 1'b1;
    set_req(3, 32'h0001_0000, 32'h0001_0000, 2'b10);
    req_valid = 4'b1000;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000 || alu_op !== 2'b10) begin
      n_fail++; $display("FAIL mul_ready: ready=%b op=%0d expected 1000 2", req_ready, alu_op);
    end
    tick();
    req_valid = '0;
    tick();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_result} !== {1'b1, 2'd3, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL mul_rsp: valid=%0b id=%0d err=%0b result=%h expected 1 3 0 0",
                         rsp_valid, rsp_id, rsp_err, rsp_result);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 32'(i), 32'd50, 2'b00);
    req_valid = 4'b0011;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0100;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL midop_full: rsp_valid=%0b ready=%b expected 1 0000", rsp_valid, req_ready);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL midop_reset: rsp_valid=%0b ready=%b expected 0 0000", rsp_valid, req_ready);
    end
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL midop_stale c=%0d: rsp_valid=%0b id=%0d expected 0", c, rsp_valid, rsp_id);
      end
      tick();
    end
    req_valid = 4'b0111;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL midop_first_grant: got %b expected 0001", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_result} !== {1'b1, 2'd0, 1'b0, 32'd50}) begin
      n_fail++; $display("FAIL midop_rsp: valid=%0b id=%0d err=%0b result=%0d expected 1 0 0 50",
                         rsp_valid, rsp_id, rsp_err, rsp_result);
    end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_div_zero();
    test_mul_trunc();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
